inst_ram_loader: RTL and testbench

Boot-time writer for the instruction RAM. It takes a byte stream from the serial receiver, assembles little-endian 32-bit words, and writes them into consecutive word addresses of `inst_ram` through that RAM's write port. While it runs it holds the CPU in reset. The CPU's fetch path is the read-only consumer of the same RAM, so the CPU executes only what this block has written.

---
 rtl/inst_loader_pkg.sv | 36 +++
 rtl/inst_ram_loader_byte_to_word.sv | 44 ++++
 rtl/inst_ram_loader.sv | 167 ++++++++++++++++
 tb/tb_inst_ram_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared state encoding and field widths for the instruction-RAM boot loader.
// INST_LOADER_CHECKSUM_EN adds the CSUM state that verifies a trailing image checksum.
package inst_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  // States in which the loader pulls bytes from the serial receiver.
  function automatic logic takes_bytes(input state_e s);
    logic t;
    t = (s == ST_LEN) || (s == ST_DATA);
`ifdef INST_LOADER_CHECKSUM_EN
    t = t || (s == ST_CSUM);
`endif
    return t;
  endfunction

endpackage

// File: rtl/inst_ram_loader_byte_to_word.sv
// Little-endian 4-byte assembler; word_vld and word_dat are combinational on the 4th accepted byte.
// No backpressure of its own: the caller qualifies in_vld with its ready.
module byte_to_word
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (in_vld) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {in_dat, shift_q[31:8]};
    end
  end

  // Exposing the completed word in the accepting cycle lets the FSM register it without an extra stage.
  assign word_vld = in_vld && !clr && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_dat = {in_dat, shift_q[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_ram_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive inst_ram words, CPU held in reset until done.
// Write strobe one cycle after the 4th data byte; in_ready drops only in WRITE. INST_LOADER_CHECKSUM_EN adds checksum check.
module inst_ram_loader
  import inst_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 18,
  parameter int unsigned MAX_WORDS  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
`endif

  logic        accept;
  logic        asm_clr;
  logic        word_vld;
  logic [31:0] word_dat;

  assign accept = in_valid && in_ready_q;

  byte_to_word u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .in_vld   (accept),
    .in_dat   (in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    asm_clr     = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN;
          idx_d      = '0;
          ram_addr_d = '0;
          asm_clr    = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_LEN: begin
        if (word_vld) begin
          len_d = word_dat;
          if (word_dat == '0)
            state_d = ST_AFTER_DATA;
          else if (word_dat > LEN_W'(MAX_WORDS))
            state_d = ST_ERROR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_vld) begin
          state_d     = ST_WRITE;
          ram_en_d    = 1'b1;
          ram_addr_d  = idx_q[ADDR_WIDTH-1:0];
          ram_wdata_d = word_dat;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d      = csum_q + word_dat;
`endif
        end
      end
      ST_WRITE: begin
        // Index carries one spare bit so a full-size image ends cleanly instead of wrapping.
        idx_d   = idx_q + 1'b1;
        state_d = (LEN_W'(idx_d) < len_q) ? ST_DATA : ST_AFTER_DATA;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (word_vld)
          state_d = (word_dat == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = takes_bytes(state_d);
    busy_d     = takes_bytes(state_d) || (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = {WORD_BYTES{ram_en_q}};
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader; checksum steps compile in with INST_LOADER_CHECKSUM_EN.
module tb_inst_ram_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [17:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [17:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_we[$];
  int          rdy_in_write = 0;

  inst_ram_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log: one entry per cycle the strobe is high.
  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
      wr_we.push_back(ram_we);
      if (in_ready !== 1'b0) rdy_in_write++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_we.delete();
    rdy_in_write = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++;
    assert (t < 50) else begin
      bad++;
      $error("FAIL send_timeout: got %0d cycles want <50", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_csum(input logic [31:0] c);
`ifdef INST_LOADER_CHECKSUM_EN
    send_word(c, 0);
`else
    if (c === 32'hx) $display("unused checksum %h", c);
`endif
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({p, "_ram_en"},   32'(ram_en),   32'd0);
    chk({p, "_ram_we"},   32'(ram_we),   32'd0);
    chk({p, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({p, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({p, "_busy"},     32'(busy),     32'd0);
    chk({p, "_done"},     32'(done),     32'd0);
    chk({p, "_error"},    32'(error),    32'd0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;

    // Reset values.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;

    // N=2: 0x12345678 @0, 0xDEADBEEF @1.
    pulse_start();
    clear_log();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    send_word(32'd2, 0);
    send_word(32'h12345678, 0);
    @(negedge clk);
    chk("t1_w0_en", 32'(ram_en), 32'd1);
    chk("t1_w0_we", 32'(ram_we), 32'hF);
    chk("t1_w0_addr", 32'(ram_addr), 32'd0);
    chk("t1_w0_data", ram_wdata, 32'h12345678);
    chk("t1_w0_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_after_w0_en", 32'(ram_en), 32'd0);
    chk("t1_after_w0_rdy", 32'(in_ready), 32'd1);
    send_word(32'hDEADBEEF, 0);
    @(negedge clk);
    chk("t1_w1_en", 32'(ram_en), 32'd1);
    chk("t1_w1_addr", 32'(ram_addr), 32'd1);
    chk("t1_w1_data", ram_wdata, 32'hDEADBEEF);
    chk("t1_cpu_hold_during", 32'(cpu_hold), 32'd1);
    send_csum(32'hF0E21567);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_nwrites", wr_addr.size(), 32'd2);

    // N=0: done right after the length, no writes.
    pulse_start();
    clear_log();
    chk("t2_done_cleared", 32'(done), 32'd0);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    send_word(32'd0, 0);
    send_csum(32'd0);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_nwrites", wr_addr.size(), 32'd0);

    // N=MAX_WORDS+1 rejected.
    pulse_start();
    clear_log();
    send_word(32'h00040001, 0);
    @(negedge clk);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_nwrites", wr_addr.size(), 32'd0);

    // start with a simultaneous byte: byte must be dropped; then N=3 with gaps.
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    clear_log();
    chk("t4_error_cleared", 32'(error), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    send_word(32'd3, $urandom_range(0, 2));
    for (int i = 0; i < 4; i++) send_byte(8'(32'h11223344 >> (8*i)), $urandom_range(0, 3));
    for (int i = 0; i < 4; i++) send_byte(8'(32'hA5A50001 >> (8*i)), $urandom_range(0, 3));
    for (int i = 0; i < 4; i++) send_byte(8'(32'hCAFEF00D >> (8*i)), $urandom_range(0, 3));
    send_csum(32'h81C62352);
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_nwrites", wr_addr.size(), 32'd3);
    chk("t4_a0", 32'(wr_addr[0]), 32'd0);
    chk("t4_a1", 32'(wr_addr[1]), 32'd1);
    chk("t4_a2", 32'(wr_addr[2]), 32'd2);
    chk("t4_d0", wr_data[0], 32'h11223344);
    chk("t4_d1", wr_data[1], 32'hA5A50001);
    chk("t4_d2", wr_data[2], 32'hCAFEF00D);
    chk("t4_we0", 32'(wr_we[0]), 32'hF);
    chk("t4_we2", 32'(wr_we[2]), 32'hF);
    chk("t4_rdy_in_write", rdy_in_write, 32'd0);

    // Reset between 2nd and 3rd data bytes.
    pulse_start();
    clear_log();
    send_word(32'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hCC;
    repeat (4) @(negedge clk);
    chk("t5_rdy_idle", 32'(in_ready), 32'd0);
    chk("t5_cpu_hold", 32'(cpu_hold), 32'd1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_nwrites", wr_addr.size(), 32'd0);

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'h00000005, 0);
    send_word(32'h00000005, 0);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_cpu_hold", 32'(cpu_hold), 32'd0);
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'h00000005, 0);
    send_word(32'h00000006, 0);
    @(negedge clk);
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_done_bad", 32'(done), 32'd0);
    chk("t6_cpu_hold_bad", 32'(cpu_hold), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
